// File: rtl/transpose_buffer_pkg.sv
// Shared types and constants for the DCT transpose buffer.
package transpose_buffer_pkg;

    localparam int COEF_W = 16;
    localparam int MAX_L  = 32;
    localparam int ROW_W  = 512;

    typedef enum logic [1:0] {SZ4, SZ8, SZ16, SZ32} sz_e;

    typedef enum logic {FILL, DRAIN} state_e;

    function automatic logic [5:0] len_of(input sz_e n);
        return 6'd4 << n;
    endfunction

endpackage

// File: rtl/transpose_buffer_coef_round_shift.sv
// Per-coefficient rounding arithmetic right shift used for inter-stage normalisation.
module coef_round_shift
    import transpose_buffer_pkg::*;
#(
    parameter int SHIFT = 0
) (
    input  logic signed [COEF_W-1:0] coef_i,
    output logic signed [COEF_W-1:0] coef_o
);

    generate
        if (SHIFT == 0) begin : g_pass
            assign coef_o = coef_i;
        end else begin : g_round
            localparam logic signed [COEF_W:0] HALF = (COEF_W+1)'(1 << (SHIFT - 1));
            logic signed [COEF_W:0] sum;

            // One guard bit so the rounding add cannot wrap before the shift.
            assign sum    = $signed({coef_i[COEF_W-1], coef_i}) + HALF;
            assign coef_o = COEF_W'(sum >>> SHIFT);
        end
    endgenerate

endmodule

// File: rtl/transpose_buffer.sv
// Single-buffered 32x32 transpose between DCT passes: FILL collects rows, DRAIN emits columns.
// Optional rounding shift of output coefficients when TRANSPOSE_ROUND_SHIFT_EN is defined.
module transpose_buffer
    import transpose_buffer_pkg::*;
#(
    parameter int SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_n,
    input  logic [ROW_W-1:0] in_row,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_n,
    output logic [ROW_W-1:0] out_col,
    output logic             out_last
);

    state_e              state_q, state_d;
    logic [4:0]          row_cnt_q, row_cnt_d;
    logic [4:0]          col_cnt_q, col_cnt_d;
    sz_e                 n_q, n_d;
    logic signed [COEF_W-1:0] mem_q [MAX_L][MAX_L];

    logic signed [COEF_W-1:0] col_raw [MAX_L];
    logic signed [COEF_W-1:0] col_rnd [MAX_L];

    sz_e        fill_n;
    logic [5:0] blk_len;
    logic       last_row;

    // The size code is only taken from the port on row 0; later rows use the latched code.
    assign fill_n   = (row_cnt_q == 5'd0) ? sz_e'(in_n) : n_q;
    assign last_row = ({1'b0, row_cnt_q} == len_of(fill_n) - 6'd1);
    assign blk_len  = len_of(n_q);

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == DRAIN);
    assign out_n     = n_q;
    assign out_last  = out_valid && ({1'b0, col_cnt_q} == blk_len - 6'd1);

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        col_cnt_d = col_cnt_q;
        n_d       = n_q;
        case (state_q)
            FILL: begin
                if (in_valid) begin
                    if (row_cnt_q == 5'd0) begin
                        n_d = sz_e'(in_n);
                    end
                    if (last_row) begin
                        row_cnt_d = 5'd0;
                        state_d   = DRAIN;
                    end else begin
                        row_cnt_d = row_cnt_q + 5'd1;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (out_last) begin
                        col_cnt_d = 5'd0;
                        state_d   = FILL;
                    end else begin
                        col_cnt_d = col_cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            row_cnt_q <= 5'd0;
            col_cnt_q <= 5'd0;
            n_q       <= SZ4;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            col_cnt_q <= col_cnt_d;
            n_q       <= n_d;
        end
    end

    // Array holds data only; it is never reset.
    always_ff @(posedge clk) begin
        if (!rst && state_q == FILL && in_valid) begin
            for (int c = 0; c < MAX_L; c++) begin
                mem_q[row_cnt_q][c] <= in_row[ROW_W-1-COEF_W*c -: COEF_W];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < MAX_L; i++) begin
            col_raw[i] = mem_q[i][col_cnt_q];
        end
    end

`ifdef TRANSPOSE_ROUND_SHIFT_EN
    for (genvar g = 0; g < MAX_L; g++) begin : g_rs
        coef_round_shift #(.SHIFT(SHIFT)) u_rs (
            .coef_i (col_raw[g]),
            .coef_o (col_rnd[g])
        );
    end
`else
    localparam int unused_shift = SHIFT;
    assign col_rnd = col_raw;
`endif

    always_comb begin
        out_col = '0;
        for (int i = 0; i < MAX_L; i++) begin
            if (out_valid && (6'(i) < blk_len)) begin
                out_col[ROW_W-1-COEF_W*i -: COEF_W] = col_rnd[i];
            end
        end
    end

endmodule

// File: tb/tb_transpose_buffer.sv
// Directed bench for transpose_buffer: table-driven 4x4 block plus multi-cycle corner sequences.
module tb_transpose_buffer;

`ifdef TRANSPOSE_ROUND_SHIFT_EN
    localparam int TB_SHIFT = 2;
`else
    localparam int TB_SHIFT = 0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_n;
    logic [511:0] in_row;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_n;
    logic [511:0] out_col;
    logic         out_last;

    int checks;
    int failures;

    typedef struct {
        logic [63:0] row_hi;
        logic [63:0] col_hi;
        logic        last;
    } vec_t;

    vec_t tab [4];

    transpose_buffer #(.SHIFT(TB_SHIFT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_n      (in_n),
        .in_row    (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_n     (out_n),
        .out_col   (out_col),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rnd(input logic [15:0] v);
`ifdef TRANSPOSE_ROUND_SHIFT_EN
        logic signed [16:0] s;
        logic signed [16:0] t;
        s = $signed({v[15], v}) + 17'sd2;
        t = s >>> 2;
        return t[15:0];
`else
        return v;
`endif
    endfunction

    function automatic logic [511:0] rnd_col(input logic [511:0] c);
        logic [511:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) v[511-16*i -: 16] = rnd(c[511-16*i -: 16]);
        return v;
    endfunction

    function automatic logic [511:0] make_row(input int mul, input int r);
        logic [511:0] v;
        v = '0;
        for (int c = 0; c < 32; c++) v[511-16*c -: 16] = 16'(r * mul + c);
        return v;
    endfunction

    function automatic logic [511:0] exp_col(input int L, input int j, input int mul);
        logic [511:0] v;
        v = '0;
        for (int i = 0; i < L; i++) v[511-16*i -: 16] = rnd(16'(i * mul + j));
        return v;
    endfunction

    task automatic send_row(input logic [1:0] n, input logic [511:0] row);
        in_valid = 1'b1;
        in_n     = n;
        in_row   = row;
        for (int k = 0; k < 50 && !in_ready; k++) tick();
        chk("in_ready_wait", 512'(in_ready), 512'(1));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain_check(input int L, input int mul, input logic [1:0] n, input string name);
        out_ready = 1'b1;
        for (int j = 0; j < L; j++) begin
            chk({name, "_col"}, out_col, exp_col(L, j, mul));
            chk({name, "_vld_last_n"}, 512'({out_valid, out_last, out_n}),
                512'({1'b1, (j == L - 1), n}));
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic table_block(input string name);
        for (int r = 0; r < 4; r++) send_row(2'd0, {tab[r].row_hi, 448'd0});
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk({name, "_col"}, out_col, rnd_col({tab[j].col_hi, 448'd0}));
            chk({name, "_last"}, 512'({out_valid, out_last}), 512'({1'b1, tab[j].last}));
            tick();
        end
        out_ready = 1'b0;
        chk({name, "_in_ready_after"}, 512'(in_ready), 512'(1));
    endtask

    initial begin
        int j;
        int k;
        logic rdy;
        logic [3:0] pat;

        tab[0] = '{64'h0000_0001_0002_0003, 64'h0000_0010_0020_0030, 1'b0};
        tab[1] = '{64'h0010_0011_0012_0013, 64'h0001_0011_0021_0031, 1'b0};
        tab[2] = '{64'h0020_0021_0022_0023, 64'h0002_0012_0022_0032, 1'b0};
        tab[3] = '{64'h0030_0031_0032_0033, 64'h0003_0013_0023_0033, 1'b1};

        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_n      = 2'd0;
        in_row    = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("reset_ctrl", 512'({in_ready, out_valid, out_last, out_n}), 512'({1'b1, 1'b0, 1'b0, 2'd0}));
        chk("reset_col", out_col, '0);
        rst = 1'b0;
        tick();

        // 4x4 block from the table
        table_block("n0");

        // 32x32 block with latency checks
        for (int r = 0; r < 31; r++) send_row(2'd3, make_row(32, r));
        chk("n3_no_early_valid", 512'(out_valid), 512'(0));
        send_row(2'd3, make_row(32, 31));
        chk("n3_valid_latency", 512'(out_valid), 512'(1));
        drain_check(32, 32, 2'd3, "n3");
        chk("n3_in_ready_latency", 512'(in_ready), 512'(1));

        // 16x16 block with back-pressure and ignored writes during drain
        for (int r = 0; r < 16; r++) send_row(2'd2, make_row(32, r));
        pat = 4'b1001;
        j = 0;
        k = 0;
        while (j < 16 && k < 200) begin
            rdy       = pat[3 - (k % 4)];
            out_ready = rdy;
            in_valid  = 1'b1;
            in_n      = 2'd0;
            in_row    = '1;
            chk("n2_bp_col", out_col, exp_col(16, j, 32));
            chk("n2_bp_ctrl", 512'({out_valid, in_ready, out_last, out_n}),
                512'({1'b1, 1'b0, (j == 15), 2'd2}));
            tick();
            if (rdy) j++;
            k++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("n2_bp_cols_done", 512'(j), 512'(16));
        chk("n2_bp_in_ready", 512'({in_ready, out_valid}), 512'({1'b1, 1'b0}));

        // in_n change mid-block must not alter the block size
        for (int r = 0; r < 8; r++) send_row(2'd1, make_row(32, r));
        drain_check(8, 32, 2'd1, "n1a");
        for (int r = 0; r < 8; r++) send_row((r < 2) ? 2'd1 : 2'd3, make_row(16, r));
        chk("n1b_size_held", 512'({out_valid, out_n}), 512'({1'b1, 2'd1}));
        drain_check(8, 16, 2'd1, "n1b");

        // reset in the middle of a fill
        for (int r = 0; r < 5; r++) send_row(2'd2, make_row(7, r + 100));
        rst = 1'b1;
        tick();
        chk("midrst_ctrl", 512'({in_ready, out_valid, out_last, out_n}), 512'({1'b1, 1'b0, 1'b0, 2'd0}));
        chk("midrst_col", out_col, '0);
        rst = 1'b0;
        table_block("post_rst");

`ifdef TRANSPOSE_ROUND_SHIFT_EN
        in_row = '0;
        send_row(2'd0, {16'h0005, 16'hFFFB, 16'h7FFF, 464'd0});
        for (int r = 1; r < 4; r++) send_row(2'd0, '0);
        out_ready = 1'b1;
        chk("rnd_pos", 512'(out_col[511:496]), 512'(16'h0001));
        tick();
        chk("rnd_neg", 512'(out_col[511:496]), 512'(16'hFFFF));
        tick();
        chk("rnd_max", 512'(out_col[511:496]), 512'(16'h2000));
        tick();
        tick();
        out_ready = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/transpose_buffer.md
Name: transpose_buffer

Overview:
- Sits directly downstream of the 1D DCT-II output permutation stage.
- Collects L = 4<<N permuted coefficient rows (512-bit packed, 32 × 16-bit) into a 32×32 register array.
- Then emits the block column by column in the same packing, so the second (column) 1D DCT pass can consume it.
- Single-buffered: alternates FILL and DRAIN phases, with a valid/ready handshake on both sides.

Parameters:
- SHIFT, 0, arithmetic right-shift with rounding applied to each output coefficient (used only when the optional feature is compiled in; range 0..15).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  in_row holds a valid row this cycle
- in_ready  output  1  buffer can accept a row
- in_n  input  2  block size code (0:4, 1:8, 2:16, 3:32); sampled only on row 0 of a block
- in_row  input  512  packed signed 16-bit coefficients; coeff c at bits [511-16c -: 16]; bits beyond L coeffs are don't-care
- out_valid  output  1  out_col holds a valid column
- out_ready  input  1  downstream accepts column
- out_n  output  2  size code of the block being drained
- out_col  output  512  column j packed as {M[0][j], M[1][j], …, M[L-1][j], zeros}
- out_last  output  1  high with the final column (j = L-1) of a block

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - state = FILL, row_cnt = 0, col_cnt = 0, n_reg = 0.
  - in_ready = 1, out_valid = 0, out_last = 0, out_n = 0, out_col = 0.
  - The array itself is not reset.
- Block length: L = 4 << n_reg.
- FILL:
  - in_ready = 1.
  - On in_valid & in_ready, row r = row_cnt gets M[r][c] = in_row coeff c for c < L.
  - On row 0, n_reg <= in_n. in_n is ignored on rows 1..L-1.
  - row_cnt increments. On r = L-1: row_cnt <= 0, state <= DRAIN.
- DRAIN:
  - in_ready = 0, out_valid = 1, out_n = n_reg.
  - out_col is driven combinationally from the array and col_cnt.
  - out_last = (col_cnt == L-1).
  - On out_valid & out_ready, col_cnt increments. On the last column: col_cnt <= 0, state <= FILL.
- out_col bits beyond 16·L are zero. Whenever out_valid = 0, out_col = 0.
- Latency:
  - The last row accepted in cycle t gives out_valid = 1 in cycle t+1, showing column 0.
  - The last column accepted in cycle t gives in_ready = 1 in cycle t+1.
- Back-pressure: out_ready low holds col_cnt, out_col and out_valid stable. There is no timeout.
- in_valid while in_ready = 0 is ignored; upstream must hold the row.
- N = 0 block: exactly 4 rows in, 4 columns out. N = 3: 32 rows, 32 columns.
- Mid-operation reset: partial fill or drain is discarded, and the block returns to reset values in the next cycle.
- in_n changing mid-block has no effect until the next row 0.

Optional Feature:
- Macro TRANSPOSE_ROUND_SHIFT_EN.
- Defined: each output coefficient = (v + (1 << (SHIFT-1))) >>> SHIFT, with the sum computed at 17 bits and the result truncated to 16 bits. SHIFT = 0 passes v unchanged. This is the inter-stage normalisation.
- Undefined: coefficients pass unchanged and SHIFT is unused.

Decomposition:
- Shared package (e.g. dct_pkg):
  - COEF_W = 16, MAX_L = 32, ROW_W = 512.
  - Size-code typedef (2-bit enum SZ4/SZ8/SZ16/SZ32).
  - Function len_of(n) = 4 << n.
  - Typedef for the FSM state {FILL, DRAIN}.
- One natural sub-module: coef_round_shift. It is a per-coefficient rounding shifter, instantiated 32× under the macro.

Test Plan:
- N = 0, rows coeff(r,c) = 16·r + c → four columns; column 1 = {0x0001, 0x0011, 0x0021, 0x0031, 448'd0}, and out_last is high on column 3.
- N = 3, coeff(r,c) = r·32 + c, out_ready held high → 32 columns, each column j has element i = i·32 + j. out_valid asserts 1 cycle after row 31 and in_ready returns 1 cycle after column 31.
- N = 2, out_ready toggled 1-0-0-1 during drain → each column held stable while out_ready is 0; no column skipped or repeated; in_valid pulses during DRAIN are not written.
- N = 1 block, then in_n changed to 3 on row 2 of the next block (started with in_n = 1) → second block is still treated as 8×8 and out_n = 1.
- rst asserted after 5 of 16 rows → next cycle in_ready = 1, out_valid = 0. A fresh N = 0 block then drains correctly with no stale data.
- With TRANSPOSE_ROUND_SHIFT_EN and SHIFT = 2: input coeffs 5, -5, 0x7FFF → outputs 1, -1, 0x2000.
